// File: rtl/seq_alu_if.sv
// Operand/handshake/result bundle between the switch/LED layer and seq_alu_core.
interface seq_alu_if #(
   parameter int unsigned W = 32
);
   logic [W-1:0] din;
   logic         ld_a;
   logic         ld_b;
   logic [3:0]   op;
   logic         start;
   logic         busy;
   logic         done;
   logic [W-1:0] F;
   logic [3:0]   FR;

   modport master (output din, ld_a, ld_b, op, start, input busy, done, F, FR);
   modport slave  (input din, ld_a, ld_b, op, start, output busy, done, F, FR);
endinterface

// File: rtl/seq_alu_core.sv
// Single-clock ALU: one-cycle logic/arithmetic, iterative shifts and shift-add multiply.
// F/FR change only on completion; FR = {ZF, SF, OF, CF}.
module seq_alu_core #(
   parameter int unsigned W = 32,
   localparam int unsigned SHW = $clog2(W)
) (
   input logic      clk,
   input logic      rst,
   seq_alu_if.slave bus
);

   typedef enum logic [0:0] {StIdle, StRun} state_e;

   state_e         state_q, state_d;
   logic [W-1:0]   a_q, a_d, b_q, b_d, f_q, f_d;
   logic [3:0]     fr_q, fr_d, op_q, op_d;
   logic [W-1:0]   lo_q, lo_d, hi_q, hi_d;
   logic [SHW:0]   cnt_q, cnt_d;
   logic           done_q, done_d;

   logic [W-1:0]   res;
   logic [W:0]     sum;
   logic [W:0]     step_sum;
   logic [SHW-1:0] shamt;
   logic           cf, of, fin, launch, step_bit;

   assign shamt    = b_q[SHW-1:0];
   assign bus.busy = (state_q == StRun);
   assign bus.done = done_q;
   assign bus.F    = f_q;
   assign bus.FR   = fr_q;

   always_comb begin
      state_d  = state_q;
      a_d      = a_q;
      b_d      = b_q;
      f_d      = f_q;
      fr_d     = fr_q;
      op_d     = op_q;
      lo_d     = lo_q;
      hi_d     = hi_q;
      cnt_d    = cnt_q;
      done_d   = 1'b0;
      res      = '0;
      sum      = '0;
      step_sum = '0;
      cf       = 1'b0;
      of       = 1'b0;
      fin      = 1'b0;
      launch   = 1'b0;
      step_bit = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (bus.ld_a) a_d = bus.din;
            if (bus.ld_b) b_d = bus.din;
            if (bus.start) begin
               op_d = bus.op;
               fin  = 1'b1;
               case (bus.op)
                  4'h0: res = a_q & b_q;
                  4'h1: res = a_q | b_q;
                  4'h2: res = a_q ^ b_q;
                  4'h3: res = ~(a_q | b_q);
                  4'h4: begin
                     sum = {1'b0, a_q} + {1'b0, b_q};
                     res = sum[W-1:0];
                     cf  = sum[W];
                     of  = (a_q[W-1] == b_q[W-1]) && (res[W-1] != a_q[W-1]);
                  end
                  4'h5: begin
                     // Zero-extended subtract: the extra top bit is the borrow.
                     sum = {1'b0, a_q} - {1'b0, b_q};
                     res = sum[W-1:0];
                     cf  = sum[W];
                     of  = (a_q[W-1] != b_q[W-1]) && (res[W-1] != a_q[W-1]);
                  end
                  4'h6: res = {{(W-1){1'b0}}, $signed(a_q) < $signed(b_q)};
                  4'h7: res = {{(W-1){1'b0}}, a_q < b_q};
                  4'h8, 4'h9, 4'hA: begin
                     if (shamt == '0) res = a_q;
                     else begin
                        launch = 1'b1;
                        cnt_d  = {1'b0, shamt};
                     end
                  end
                  4'hB: begin
                     launch = 1'b1;
                     cnt_d  = (SHW + 1)'(W);
                  end
                  default: res = '0;
               endcase
               if (launch) begin
                  fin     = 1'b0;
                  state_d = StRun;
                  lo_d    = a_q;
                  hi_d    = '0;
                  // Operands stay frozen for the whole multi-cycle run.
                  a_d     = a_q;
                  b_d     = b_q;
               end
            end
         end
         StRun: begin
            cnt_d = cnt_q - 1'b1;
            case (op_q)
               4'h8: begin
                  step_bit = lo_q[W-1];
                  lo_d     = {lo_q[W-2:0], 1'b0};
               end
               4'h9: begin
                  step_bit = lo_q[0];
                  lo_d     = {1'b0, lo_q[W-1:1]};
               end
               4'hA: begin
                  step_bit = lo_q[0];
                  lo_d     = {lo_q[W-1], lo_q[W-1:1]};
               end
               default: begin
                  // {hi, lo} accumulates the product while lo's low bits retire the multiplier.
                  step_sum     = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
                  {hi_d, lo_d} = {step_sum, lo_q[W-1:1]};
               end
            endcase
            if (cnt_q == (SHW + 1)'(1)) begin
               fin     = 1'b1;
               state_d = StIdle;
               res     = lo_d;
               if (op_q == 4'hB) begin
                  cf = (hi_d != '0);
                  of = cf;
               end else begin
                  cf = step_bit;
               end
            end
         end
         default: state_d = StIdle;
      endcase

      if (fin) begin
         f_d    = res;
         fr_d   = {res == '0, res[W-1], of, cf};
         done_d = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
         a_q     <= '0;
         b_q     <= '0;
         f_q     <= '0;
         fr_q    <= '0;
         op_q    <= '0;
         lo_q    <= '0;
         hi_q    <= '0;
         cnt_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         f_q     <= f_d;
         fr_q    <= fr_d;
         op_q    <= op_d;
         lo_q    <= lo_d;
         hi_q    <= hi_d;
         cnt_q   <= cnt_d;
         done_q  <= done_d;
      end
   end

endmodule

// File: tb/tb_seq_alu_core.sv
// Randomized and directed bench for seq_alu_core against an arithmetic reference model.
module tb_seq_alu_core;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   total = 0;
   int   bad = 0;
   logic [31:0] ma = '0, mb = '0;

   seq_alu_if #(.W(32)) bus ();

   seq_alu_core #(.W(32)) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;

   // Expected F, FR and busy-cycle count straight from the operation rules.
   task automatic model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] f, output logic [3:0] fr, output int n);
      longint unsigned p;
      longint sr;
      logic cf, of;
      int amt;
      cf  = 1'b0;
      of  = 1'b0;
      n   = 0;
      amt = int'(b[4:0]);
      f   = '0;
      case (op)
         4'h0: f = a & b;
         4'h1: f = a | b;
         4'h2: f = a ^ b;
         4'h3: f = ~(a | b);
         4'h4: begin
            p  = longint'(a) + longint'(b);
            f  = p[31:0];
            cf = p[32];
            sr = longint'($signed(a)) + longint'($signed(b));
            of = (sr != longint'($signed(f)));
         end
         4'h5: begin
            f  = a - b;
            cf = (a < b);
            sr = longint'($signed(a)) - longint'($signed(b));
            of = (sr != longint'($signed(f)));
         end
         4'h6: f = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         4'h7: f = (a < b) ? 32'd1 : 32'd0;
         4'h8: begin
            f = a << amt;
            if (amt != 0) begin cf = a[32 - amt]; n = amt; end
         end
         4'h9: begin
            f = a >> amt;
            if (amt != 0) begin cf = a[amt - 1]; n = amt; end
         end
         4'hA: begin
            f = $signed(a) >>> amt;
            if (amt != 0) begin cf = a[amt - 1]; n = amt; end
         end
         4'hB: begin
            p  = longint'(a) * longint'(b);
            f  = p[31:0];
            cf = (p[63:32] != 0);
            of = cf;
            n  = 32;
         end
         default: f = '0;
      endcase
      fr = {f == 0, f[31], of, cf};
   endtask

   task automatic load_ab(input logic [31:0] a, input logic [31:0] b);
      @(negedge clk);
      bus.din = a; bus.ld_a = 1'b1;
      @(negedge clk);
      bus.ld_a = 1'b0; bus.din = b; bus.ld_b = 1'b1;
      @(negedge clk);
      bus.ld_b = 1'b0;
      ma = a;
      mb = b;
   endtask

   // Launch op, then check latency, done pulse shape, F and FR.
   task automatic do_op(input logic [3:0] op, input string name);
      logic [31:0] ef;
      logic [3:0]  efr;
      int n, cyc;
      model(op, ma, mb, ef, efr, n);
      @(negedge clk);
      bus.op = op; bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      cyc = 0;
      while (bus.busy === 1'b1 && cyc < 100) begin
         total++;
         if (bus.done !== 1'b0) begin
            bad++; $display("FAIL %s done_with_busy: got %b want 0", name, bus.done);
         end
         @(negedge clk);
         cyc++;
      end
      total++;
      if (cyc !== n) begin bad++; $display("FAIL %s latency: got %0d want %0d", name, cyc, n); end
      total++;
      if (bus.done !== 1'b1) begin bad++; $display("FAIL %s done: got %b want 1", name, bus.done); end
      total++;
      if (bus.F !== ef) begin bad++; $display("FAIL %s F: got %h want %h", name, bus.F, ef); end
      total++;
      if (bus.FR !== efr) begin bad++; $display("FAIL %s FR: got %b want %b", name, bus.FR, efr); end
      @(negedge clk);
      total++;
      if (bus.done !== 1'b0) begin bad++; $display("FAIL %s done_pulse: got %b want 0", name, bus.done); end
   endtask

   task automatic test_reset;
      #1;
      total++;
      if ({bus.F, bus.FR, bus.busy, bus.done} !== 38'd0) begin
         bad++; $display("FAIL reset_state: got %h want 0", {bus.F, bus.FR, bus.busy, bus.done});
      end
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_directed;
      load_ab(32'h7FFF_FFFF, 32'h1);  do_op(4'h4, "add_ovf");
      load_ab(32'd5, 32'd5);          do_op(4'h5, "sub_zero");
      load_ab(32'd0, 32'd1);          do_op(4'h5, "sub_borrow");
      load_ab(32'h8000_0000, 32'd4);  do_op(4'hA, "sra4");
      load_ab(32'h8000_0000, 32'd0);  do_op(4'hA, "sra0");
      load_ab(32'd3, 32'd5);          do_op(4'hB, "mul_small");
      load_ab(32'h1_0000, 32'h1_0000); do_op(4'hB, "mul_ovf");
      load_ab(32'd7, 32'd9);          do_op(4'hD, "illegal");
   endtask

   task automatic test_random;
      for (int i = 0; i < 40; i++) begin
         load_ab($urandom, $urandom);
         do_op(4'($urandom_range(0, 15)), "random");
      end
   endtask

   task automatic test_busy_ignore;
      int cyc;
      load_ab(32'd3, 32'd5);
      @(negedge clk);
      bus.op = 4'hB; bus.start = 1'b1;
      repeat (3) @(negedge clk);
      bus.start = 1'b1; bus.op = 4'h4; bus.ld_a = 1'b1; bus.din = 32'hFFFF;
      @(negedge clk);
      bus.start = 1'b0; bus.ld_a = 1'b0;
      cyc = 0;
      while (bus.busy === 1'b1 && cyc < 100) begin @(negedge clk); cyc++; end
      total++;
      if (bus.done !== 1'b1 || bus.F !== 32'd15) begin
         bad++; $display("FAIL busy_ignore_mul: got done=%b F=%h want done=1 F=0000000f", bus.done, bus.F);
      end
      @(negedge clk);
      do_op(4'h4, "busy_ignore_add");  // A must still be 3 -> 8
   endtask

   task automatic test_reset_mid;
      load_ab(32'd3, 32'd5);
      do_op(4'h4, "pre_reset_add");
      @(negedge clk);
      bus.op = 4'hB; bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (9) @(negedge clk);
      rst = 1'b1;
      #1;
      total++;
      if ({bus.F, bus.FR, bus.busy, bus.done} !== 38'd0) begin
         bad++; $display("FAIL reset_mid: got %h want 0", {bus.F, bus.FR, bus.busy, bus.done});
      end
      ma = '0; mb = '0;
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         total++;
         if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
            bad++; $display("FAIL reset_no_done: got done=%b busy=%b want 0 0", bus.done, bus.busy);
         end
      end
      do_op(4'h4, "reset_add_zero");
      load_ab(32'd20, 32'd22);
      do_op(4'h4, "post_reset_add");
   endtask

   // Load coinciding with a single-cycle start: op uses old A, load still lands.
   task automatic test_load_with_start;
      load_ab(32'd10, 32'd20);
      @(negedge clk);
      bus.op = 4'h4; bus.start = 1'b1; bus.ld_a = 1'b1; bus.din = 32'd100;
      @(negedge clk);
      bus.start = 1'b0; bus.ld_a = 1'b0;
      total++;
      if (bus.F !== 32'd30) begin bad++; $display("FAIL load_with_start: got %h want 0000001e", bus.F); end
      ma = 32'd100;
      do_op(4'h4, "load_landed");
   endtask

   initial begin
      bus.din = '0; bus.ld_a = 1'b0; bus.ld_b = 1'b0; bus.op = '0; bus.start = 1'b0;
      test_reset;
      test_directed;
      test_random;
      test_busy_ignore;
      test_reset_mid;
      test_load_with_start;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
